// File: rtl/light_pkg.sv
// Shared constants and FSM encoding for the light sensor ADC front end.
package light_pkg;

    localparam int unsigned ADC_BITS  = 8;
    // Half-period 0 is the setup phase; halves 1..16 are the 8 low/high SCLK phases.
    localparam int unsigned HALF_LAST = 2 * ADC_BITS;
    localparam int unsigned HALF_W    = $clog2(HALF_LAST + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        WAIT  = 3'd4
    } state_t;

endpackage

// File: rtl/light_adc_shift.sv
// SCLK half-period divider, bit counter and MSB-first shift register for one ADC frame.
module light_adc_shift
    import light_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sdata,
    output logic                sclk,
    output logic                setup_end_c,
    output logic                done_c,
    output logic [ADC_BITS-1:0] data
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic              active;
    logic [DIV_W-1:0]  div_cnt;
    logic [HALF_W-1:0] half;
    logic              half_end_c;

    assign half_end_c  = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign setup_end_c = half_end_c && (half == '0);
    assign done_c      = half_end_c && (half == HALF_W'(HALF_LAST));

    // Odd halves drive SCLK low, even halves high; data is captured on each 0->1 transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            half    <= '0;
            sclk    <= 1'b0;
            data    <= '0;
        end else if (start && !active) begin
            active  <= 1'b1;
            div_cnt <= '0;
            half    <= '0;
            sclk    <= 1'b0;
        end else if (half_end_c) begin
            div_cnt <= '0;
            if (done_c) begin
                active <= 1'b0;
                half   <= '0;
                sclk   <= 1'b0;
            end else begin
                half <= half + 1'b1;
                sclk <= half[0];
                if (half[0]) begin
                    data <= {data[ADC_BITS-2:0], sdata};
                end
            end
        end else if (active) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/light_adc_reader.sv
// Serial light-sensor ADC reader: frame sequencing, chip select, conversion wait and block averager.
module light_adc_reader
    import light_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 25,
    parameter int unsigned CONV_WAIT = 1000,
    parameter int unsigned AVG_LOG2  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                adc_dout,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [ADC_BITS-1:0] light,
    output logic                valid
);

    localparam int unsigned ACC_W  = ADC_BITS + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;
    localparam int unsigned NSAMP  = 1 << AVG_LOG2;
    localparam int unsigned WAIT_W = $clog2(CONV_WAIT + 1);

    state_t              state;
    state_t              state_next;
    logic                start_c;
    logic                setup_end_c;
    logic                done_c;
    logic [ADC_BITS-1:0] sample;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_total_c;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_inc_c;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_end_c;

    light_adc_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_c),
        .sdata       (adc_dout),
        .sclk        (adc_sclk),
        .setup_end_c (setup_end_c),
        .done_c      (done_c),
        .data        (sample)
    );

    assign acc_total_c = acc + ACC_W'(sample);
    assign count_inc_c = count + 1'b1;
    assign wait_end_c  = (wait_cnt == WAIT_W'(CONV_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; EN only matters in IDLE and on the last WAIT cycle.
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        case (state)
            IDLE:    if (en) state_next = SETUP;
            SETUP:   if (setup_end_c) state_next = SHIFT;
            SHIFT:   if (done_c) state_next = DONE;
            DONE:    state_next = WAIT;
            WAIT:    if (wait_end_c) state_next = en ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
        start_c = (state_next == SETUP) && (state != SETUP);
    end

    // Registered outputs and averager; the accumulate happens on the edge entering DONE
    // so VALID and the new LIGHT coincide with CS_N returning high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_cs_n <= 1'b1;
            light    <= '0;
            valid    <= 1'b0;
            acc      <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            adc_cs_n <= !((state_next == SETUP) || (state_next == SHIFT));
            valid    <= 1'b0;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (state == IDLE) begin
                acc   <= '0;
                count <= '0;
            end else if ((state == SHIFT) && done_c) begin
                if (count_inc_c == CNT_W'(NSAMP)) begin
                    light <= ADC_BITS'(acc_total_c >> AVG_LOG2);
                    valid <= 1'b1;
                    acc   <= '0;
                    count <= '0;
                end else begin
                    acc   <= acc_total_c;
                    count <= count_inc_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_light_adc_reader.sv
// Scoreboard bench for light_adc_reader: serial ADC model, averaging reference and protocol checker.
module tb_light_adc_reader;

    localparam int CLK_DIV      = 25;
    localparam int CONV_WAIT    = 1000;
    localparam int AVG_LOG2     = 2;
    localparam int NSAMP        = 1 << AVG_LOG2;
    localparam int FRAME_BUDGET = 2 * (17 * CLK_DIV + CONV_WAIT + 10);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       adc_dout = 1'b0;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [7:0] light;
    logic       valid;

    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_q[$];
    int         win_q[$];
    logic [7:0] plan_q[$];
    bit         discard_pending = 0;
    int         light_ref = 0;
    int         frames_started = 0;
    int         frames_ended = 0;
    logic [7:0] adc_byte = 8'h00;

    light_adc_reader #(
        .CLK_DIV   (CLK_DIV),
        .CONV_WAIT (CONV_WAIT),
        .AVG_LOG2  (AVG_LOG2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .adc_dout (adc_dout),
        .adc_cs_n (adc_cs_n),
        .adc_sclk (adc_sclk),
        .light    (light),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference averager: every NSAMP completed frames yield floor(sum / NSAMP).
    function automatic void model_frame(input int b);
        int sum;
        if (discard_pending) begin
            win_q.delete();
            discard_pending = 0;
        end
        win_q.push_back(b);
        if (win_q.size() == NSAMP) begin
            sum = 0;
            foreach (win_q[i]) sum += win_q[i];
            exp_q.push_back(sum / NSAMP);
            win_q.delete();
        end
    endfunction

    // ADC model: MSB valid at CS_N fall, next bit after each SCLK fall.
    always @(negedge adc_cs_n) begin
        if (rst_n) begin
            if (plan_q.size() > 0) adc_byte = plan_q.pop_front();
            else adc_byte = 8'($urandom_range(0, 255));
            adc_dout = adc_byte[7];
            model_frame(int'(adc_byte));
        end
    end

    always @(negedge adc_sclk) begin
        if (!adc_cs_n) begin
            adc_byte = {adc_byte[6:0], 1'b0};
            adc_dout = adc_byte[7];
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        win_q.delete();
        discard_pending = 0;
        light_ref = 0;
    end

    // Monitor: scoreboard pops on VALID, plus SCLK/CS_N protocol checks.
    bit prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0;
    bit have_prev = 1'b0, gap_en_ok = 1'b0;
    int gap_cnt = 0, low_cnt = 0, rises = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_valid = 1'b0;
            have_prev = 1'b0; gap_en_ok = 1'b0;
            gap_cnt = 0; low_cnt = 0; rises = 0;
        end else begin
            if (valid) begin
                check("valid_one_cycle", int'(prev_valid), 0);
                check("valid_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    light_ref = exp_q.pop_front();
                    check("light_update", int'(light), light_ref);
                end
            end else begin
                check("light_hold", int'(light), light_ref);
            end
            if (adc_cs_n) begin
                check("sclk_idle_low", int'(adc_sclk), 0);
                if (!prev_cs) begin
                    check("cs_low_cycles", low_cnt, 17 * CLK_DIV);
                    check("sclk_rises", rises, 8);
                    frames_ended++;
                    have_prev = 1'b1;
                    gap_cnt = 0;
                    gap_en_ok = 1'b1;
                end
                gap_cnt++;
                if (!en) gap_en_ok = 1'b0;
            end else begin
                if (prev_cs) begin
                    if (have_prev && gap_en_ok) check("cs_gap", gap_cnt, CONV_WAIT + 1);
                    low_cnt = 0;
                    rises = 0;
                    frames_started++;
                end
                low_cnt++;
                if (adc_sclk && !prev_sclk) rises++;
            end
            prev_cs = adc_cs_n;
            prev_sclk = adc_sclk;
            prev_valid = valid;
        end
    end

    task automatic wait_started(input int n);
        int target;
        int t;
        target = frames_started + n;
        t = 0;
        while (frames_started < target && t < n * FRAME_BUDGET) begin
            @(negedge clk);
            t++;
        end
        check("frame_start_timeout", (frames_started >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_ended(input int n);
        int target;
        int t;
        target = frames_ended + n;
        t = 0;
        while (frames_ended < target && t < n * FRAME_BUDGET) begin
            @(negedge clk);
            t++;
        end
        check("frame_end_timeout", (frames_ended >= target) ? 1 : 0, 1);
    endtask

    initial begin
        plan_q = '{8'd100, 8'd110, 8'd120, 8'd130,
                   8'd1,   8'd1,   8'd1,   8'd2,
                   8'd255, 8'd255, 8'd255, 8'd255};
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", int'(adc_cs_n), 1);
        check("rst_sclk", int'(adc_sclk), 0);
        check("rst_light", int'(light), 0);
        check("rst_valid", int'(valid), 0);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_en_cs_n", int'(adc_cs_n), 1);

        // Three planned averaging windows: 115, 1, 255.
        #1 en = 1'b1;
        wait_started(12);
        wait_ended(1);

        // Drop EN during SHIFT of the second frame of a window.
        wait_started(1);
        wait_started(1);
        repeat (3 * CLK_DIV) @(negedge clk);
        #1 en = 1'b0;
        discard_pending = 1;
        wait_ended(1);
        repeat (CONV_WAIT + 50) @(negedge clk);
        check("idle_after_drop_cs_n", int'(adc_cs_n), 1);
        check("idle_after_drop_light", int'(light), 255);

        // Fresh random windows after re-enable.
        #1 en = 1'b1;
        wait_started(8);
        wait_ended(1);

        // Asynchronous reset in the middle of SHIFT.
        wait_started(1);
        repeat (3 * CLK_DIV) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs_n", int'(adc_cs_n), 1);
        check("midrst_sclk", int'(adc_sclk), 0);
        check("midrst_light", int'(light), 0);
        check("midrst_valid", int'(valid), 0);
        repeat (3) @(negedge clk);
        plan_q = '{8'd7, 8'd9, 8'd200, 8'd33};
        #1 rst_n = 1'b1;
        wait_started(4);
        wait_ended(1);
        repeat (20) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        check("final_light", int'(light), 62);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
